// File: rtl/dac_spi_responder.sv
// dac_spi_responder: SPI responder for the 16-bit DAC serial link.
// Every SPI input is oversampled in the clk domain. Frames are framed by an
// active-low nsync and carry data MSB first. The received word is committed
// to dac_code, and the previously committed code is shifted back on MISO.
//
// Handshake: there is no valid/ready pair. code_valid and frame_err are
// single-cycle, mutually exclusive strobes issued in the COMMIT cycle. A
// strobe is never stalled. dac_code holds its value until the next
// code_valid.
module dac_spi_responder #(
    parameter int                 DATA_W      = 16,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  RESET_CODE  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_nsync,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] dac_code,
    output logic              code_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, nsync_sync, mosi_sync;
    logic                   sclk_hist, nsync_hist;
    logic [SYNC_STAGES:0]   flush;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   ovf;
    logic [DATA_W-1:0]      rx_shreg, tx_shreg;

    logic sclk_s, nsync_s, mosi_s;
    logic sclk_rise, sclk_fall, nsync_rise, nsync_fall, frame_start;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign nsync_s     = nsync_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_hist;
    assign sclk_fall   = ~sclk_s & sclk_hist;
    assign nsync_rise  = nsync_s & ~nsync_hist;
    assign nsync_fall  = ~nsync_s & nsync_hist;
    // A frame may start only after a real high level on nsync has been seen
    // since reset. If nsync is held low across reset, no frame is started.
    assign frame_start = nsync_fall & armed;
    assign busy        = (state_q == SHIFT);

    // Input synchronizers and edge-history flops. Their reset values are the
    // idle line levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            nsync_sync <= '1;
            mosi_sync  <= '0;
            sclk_hist  <= 1'b0;
            nsync_hist <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            nsync_sync <= {nsync_sync[SYNC_STAGES-2:0], spi_nsync};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_hist  <= sclk_s;
            nsync_hist <= nsync_s;
        end
    end

    // Arm frame detection once the synchronizer has flushed its reset value
    // and nsync is seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush <= '0;
            armed <= 1'b0;
        end else begin
            flush <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && nsync_s) begin
                armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = SHIFT;
            SHIFT:   if (nsync_rise)  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the shift registers, the bit counter, the commit logic and
    // the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            ovf        <= 1'b0;
            rx_shreg   <= '0;
            tx_shreg   <= '0;
            dac_code   <= RESET_CODE;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            spi_miso   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            // MISO is driven only while the frame continues. It reads 0 in
            // IDLE and COMMIT.
            spi_miso   <= (state_q == SHIFT && state_d == SHIFT) ? tx_shreg[DATA_W-1] : 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        bit_cnt  <= '0;
                        ovf      <= 1'b0;
                        tx_shreg <= dac_code;
                    end
                end
                SHIFT: begin
                    // An nsync rise discards any sclk edge seen in the same cycle.
                    if (!nsync_rise) begin
                        if (sclk_rise) begin
                            if (bit_cnt == CNT_W'(DATA_W)) begin
                                ovf <= 1'b1;
                            end else begin
                                rx_shreg <= {rx_shreg[DATA_W-2:0], mosi_s};
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                COMMIT: begin
                    if (bit_cnt == CNT_W'(DATA_W) && !ovf) begin
                        dac_code   <= rx_shreg;
                        code_valid <= 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_responder.sv
// Testbench for dac_spi_responder. A behavioural SPI master drives frames.
// A frame-level model predicts commits, errors and readback words.
module tb_dac_spi_responder;

    localparam int          DATA_W     = 16;
    localparam logic [15:0] RESET_CODE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_nsync = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] dac_code;
    logic        code_valid;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model_code = RESET_CODE;

    dac_spi_responder #(.DATA_W(16), .SYNC_STAGES(2), .RESET_CODE(RESET_CODE)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_nsync(spi_nsync),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .dac_code(dac_code),
        .code_valid(code_valid), .frame_err(frame_err), .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Pulse monitor. It counts the strobes, checks that they are mutually
    // exclusive, and checks each commit against the expected queue.
    always @(negedge clk) begin
        if (code_valid) begin
            valid_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected: dac_code=%h, no commit expected", dac_code);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dac_code !== e) begin
                    n_err++;
                    $display("FAIL commit_value: got %h expected %h", dac_code, e);
                end
            end
        end
        if (frame_err) err_cnt++;
        if (code_valid && frame_err) begin
            n_cmp++;
            n_err++;
            $display("FAIL pulse_exclusive: code_valid=1 frame_err=1 expected not both");
        end
    end

    // Master: pull nsync low and clock nbits bits. nsync is left low.
    // sclk runs at clk/8. MISO is captured at each sclk rise.
    task automatic frame_body(input logic [15:0] data, input int nbits, output logic [15:0] rb);
        rb = '0;
        spi_nsync = 1'b0;
        spi_mosi = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? data[15-i] : 1'b0;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            if (i < 16) rb[15-i] = spi_miso;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // Send one complete frame. Update the model, and check readback when the
    // full 16 bits were clocked.
    task automatic do_frame(input logic [15:0] data, input int nbits, input string tag);
        logic [15:0] rb;
        logic [15:0] prev;
        prev = model_code;
        if (nbits == DATA_W) begin
            exp_q.push_back(data);
            model_code = data;
        end
        frame_body(data, nbits, rb);
        spi_nsync = 1'b1;
        repeat (8) @(negedge clk);
        if (nbits >= DATA_W) begin
            n_cmp++;
            if (rb !== prev) begin
                n_err++;
                $display("FAIL %s_readback: got %h expected %h", tag, rb, prev);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({dac_code, code_valid, frame_err, busy, spi_miso} !== {RESET_CODE, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_outputs: got code=%h v=%b e=%b busy=%b miso=%b expected %h/0/0/0/0",
                     dac_code, code_valid, frame_err, busy, spi_miso, RESET_CODE);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [15:0] rb;
        int v0;
        v0 = valid_cnt;
        exp_q.push_back(16'hA5C3);
        frame_body(16'hA5C3, 16, rb);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        n_cmp++;
        if (rb !== 16'h0000) begin
            n_err++;
            $display("FAIL single_miso: got %h expected 0000", rb);
        end
        spi_nsync = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (code_valid !== 1'b0 || dac_code !== RESET_CODE) begin
            n_err++;
            $display("FAIL single_early: got v=%b code=%h expected 0/%h", code_valid, dac_code, RESET_CODE);
        end
        @(negedge clk);
        n_cmp++;
        if (code_valid !== 1'b1 || dac_code !== 16'hA5C3) begin
            n_err++;
            $display("FAIL single_latency: got v=%b code=%h expected 1/a5c3", code_valid, dac_code);
        end
        @(negedge clk);
        n_cmp++;
        if (code_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse_width: got v=%b busy=%b expected 0/0", code_valid, busy);
        end
        model_code = 16'hA5C3;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (valid_cnt - v0 !== 1) begin
            n_err++;
            $display("FAIL single_count: got %0d pulses expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_readback();
        do_frame(16'h1234, 16, "readback");
        n_cmp++;
        if (dac_code !== 16'h1234) begin
            n_err++;
            $display("FAIL readback_code: got %h expected 1234", dac_code);
        end
    endtask

    task automatic test_short_frame();
        int e0, v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        do_frame(16'h7FFF, 15, "short");
        n_cmp++;
        if (err_cnt - e0 !== 1 || valid_cnt !== v0 || dac_code !== model_code) begin
            n_err++;
            $display("FAIL short_frame: got err=%0d valid=%0d code=%h expected 1/0/%h",
                     err_cnt - e0, valid_cnt - v0, dac_code, model_code);
        end
        do_frame(16'h5555, 17, "long");
        n_cmp++;
        if (err_cnt - e0 !== 2 || valid_cnt !== v0 || dac_code !== model_code) begin
            n_err++;
            $display("FAIL long_frame: got err=%0d valid=%0d code=%h expected 2/0/%h",
                     err_cnt - e0, valid_cnt - v0, dac_code, model_code);
        end
    endtask

    task automatic test_idle_clocking();
        int e0, v0;
        logic busy_seen;
        do_frame(16'h00FF, 16, "idle_pre");
        e0 = err_cnt;
        v0 = valid_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            busy_seen |= busy;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            busy_seen |= busy;
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (err_cnt !== e0 || valid_cnt !== v0 || dac_code !== 16'h00FF || busy_seen !== 1'b0) begin
            n_err++;
            $display("FAIL idle_clocking: got err=%0d valid=%0d code=%h busy=%b expected 0/0/00ff/0",
                     err_cnt - e0, valid_cnt - v0, dac_code, busy_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rb;
        int e0, v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        frame_body(16'hC3C3, 8, rb);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_code = RESET_CODE;
        n_cmp++;
        if (dac_code !== RESET_CODE) begin
            n_err++;
            $display("FAIL midreset_code: got %h expected %h", dac_code, RESET_CODE);
        end
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        spi_nsync = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (err_cnt !== e0 || valid_cnt !== v0 || dac_code !== RESET_CODE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: got err=%0d valid=%0d code=%h busy=%b expected 0/0/%h/0",
                     err_cnt - e0, valid_cnt - v0, dac_code, busy, RESET_CODE);
        end
        do_frame(16'hBEEF, 16, "midreset_next");
        n_cmp++;
        if (dac_code !== 16'hBEEF || valid_cnt - v0 !== 1) begin
            n_err++;
            $display("FAIL midreset_next: got code=%h pulses=%0d expected beef/1", dac_code, valid_cnt - v0);
        end
    endtask

    task automatic test_min_spacing();
        logic [15:0] rb;
        int v0;
        v0 = valid_cnt;
        exp_q.push_back(16'h0001);
        frame_body(16'h0001, 16, rb);
        spi_nsync = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(16'hFFFE);
        frame_body(16'hFFFE, 16, rb);
        n_cmp++;
        if (rb !== 16'h0001) begin
            n_err++;
            $display("FAIL spacing_readback: got %h expected 0001", rb);
        end
        spi_nsync = 1'b1;
        repeat (8) @(negedge clk);
        model_code = 16'hFFFE;
        n_cmp++;
        if (valid_cnt - v0 !== 2 || dac_code !== 16'hFFFE) begin
            n_err++;
            $display("FAIL spacing_commit: got pulses=%0d code=%h expected 2/fffe", valid_cnt - v0, dac_code);
        end
    endtask

    task automatic test_random();
        int e0, v0, exp_e, exp_v, nb;
        logic [15:0] d;
        e0 = err_cnt;
        v0 = valid_cnt;
        exp_e = 0;
        exp_v = 0;
        for (int k = 0; k < 8; k++) begin
            d = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 4))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            if (nb == 16) exp_v++; else exp_e++;
            do_frame(d, nb, "random");
        end
        n_cmp++;
        if (err_cnt - e0 !== exp_e || valid_cnt - v0 !== exp_v || dac_code !== model_code) begin
            n_err++;
            $display("FAIL random_frames: got err=%0d valid=%0d code=%h expected %0d/%0d/%h",
                     err_cnt - e0, valid_cnt - v0, dac_code, exp_e, exp_v, model_code);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_readback();
        test_short_frame();
        test_idle_clocking();
        test_reset_mid_frame();
        test_min_spacing();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_commits: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
